// File: rtl/breath_duty_gen_if.sv
// ---------------------------------------------------------------------------
// breath_duty_gen_if
//
// Groups the run controls and the duty/phase outputs of breath_duty_gen.
//
// Signals:
//   en           : run enable (master -> slave)
//   step         : R-bit level increment/decrement per tick (master -> slave)
//   period_start : one-cycle pulse at each PWM period start (master -> slave)
//   duty         : R+1-bit duty value for the PWM core (slave -> master)
//   phase        : current breathing phase (slave -> master)
//   cycle_done   : one-cycle pulse at the end of a breath cycle (slave -> master)
// ---------------------------------------------------------------------------
interface breath_duty_gen_if #(
    parameter int R = 8
);
    logic         en;
    logic [R-1:0] step;
    logic         period_start;
    logic [R:0]   duty;
    logic [1:0]   phase;
    logic         cycle_done;

    modport master (
        output en,
        output step,
        output period_start,
        input  duty,
        input  phase,
        input  cycle_done
    );

    modport slave (
        input  en,
        input  step,
        input  period_start,
        output duty,
        output phase,
        output cycle_done
    );
endinterface

// File: rtl/breath_duty_gen.sv
// ---------------------------------------------------------------------------
// breath_duty_gen
//
// Triangular "breathing" duty sequencer for the PWM core: the internal level
// rises to full scale, holds, falls to zero, holds, and repeats. Level steps
// are paced by a prescaler tick and sized by the runtime step input. The duty
// output is only reloaded on PWM period boundaries so the PWM counter never
// sees a mid-period change.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : breath_duty_gen_if slave modport
//          (en, step, period_start in; duty, phase, cycle_done out)
//
// Parameters:
//   R          : PWM resolution, duty spans 0..2^R inclusive
//   TICK_DIV   : clk cycles per step tick (>= 2)
//   HOLD_TICKS : ticks spent in each hold phase (>= 1)
// ---------------------------------------------------------------------------
module breath_duty_gen #(
    parameter int R          = 8,
    parameter int TICK_DIV   = 2_500_000,
    parameter int HOLD_TICKS = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    breath_duty_gen_if.slave       bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [R:0]    FULL      = {1'b1, {R{1'b0}}};
    localparam logic [R+1:0]  FULL_W    = {2'b01, {R{1'b0}}};

    typedef enum logic [1:0] {
        LOW_HOLD  = 2'd0,
        RISE      = 2'd1,
        HIGH_HOLD = 2'd2,
        FALL      = 2'd3
    } phase_e;

    phase_e        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [R:0]    level_q, level_d;
    logic [R:0]    duty_q, duty_d;
    logic          cycleDone_q, cycleDone_d;

    logic          tick;
    logic [R:0]    stepEff;
    logic [R+1:0]  levelUpWide;
    logic [R:0]    levelUp;
    logic [R:0]    levelDown;

    // Tick generation and saturating level arithmetic. The rise sum is kept
    // one bit wider than the level so an overshoot past full scale is seen
    // and clamped instead of wrapping back to a small value.
    always_comb begin
        tick        = bus.en && (pcnt_q == PCNT_LAST);
        stepEff     = (bus.step == '0) ? (R+1)'(1) : {1'b0, bus.step};
        levelUpWide = {1'b0, level_q} + {1'b0, stepEff};
        levelUp     = (levelUpWide >= FULL_W) ? FULL : levelUpWide[R:0];
        levelDown   = (level_q > stepEff) ? (level_q - stepEff) : '0;
    end

    // Next-state logic for the prescaler, hold counter, level and phase.
    // duty samples the pre-tick level, so a tick coinciding with a period
    // start only reaches the PWM core at the following period start.
    always_comb begin
        pcnt_d      = pcnt_q;
        hcnt_d      = hcnt_q;
        level_d     = level_q;
        state_d     = state_q;
        cycleDone_d = 1'b0;
        duty_d      = bus.period_start ? level_q : duty_q;

        if (bus.en) begin
            pcnt_d = tick ? '0 : (pcnt_q + PW'(1));
        end

        if (tick) begin
            unique case (state_q)
                RISE: begin
                    level_d = levelUp;
                    if (levelUp == FULL) begin
                        state_d = HIGH_HOLD;
                        hcnt_d  = '0;
                    end
                end
                HIGH_HOLD: begin
                    if (hcnt_q == HCNT_LAST) begin
                        state_d = FALL;
                        hcnt_d  = '0;
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
                FALL: begin
                    level_d = levelDown;
                    if (levelDown == '0) begin
                        state_d = LOW_HOLD;
                        hcnt_d  = '0;
                    end
                end
                LOW_HOLD: begin
                    if (hcnt_q == HCNT_LAST) begin
                        state_d     = RISE;
                        hcnt_d      = '0;
                        cycleDone_d = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
                default: begin
                    state_d = RISE;
                end
            endcase
        end
    end

    // State register; reset overrides enable, tick and period_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RISE;
            pcnt_q      <= '0;
            hcnt_q      <= '0;
            level_q     <= '0;
            duty_q      <= '0;
            cycleDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            hcnt_q      <= hcnt_d;
            level_q     <= level_d;
            duty_q      <= duty_d;
            cycleDone_q <= cycleDone_d;
        end
    end

    assign bus.duty       = duty_q;
    assign bus.phase      = state_q;
    assign bus.cycle_done = cycleDone_q;

endmodule
